// File: rtl/sink_serializer_if.sv
// Word-in / byte-out handshake bundle for sink_serializer.
// The slave modport is the serializer's own view; master is the surrounding logic.
interface sink_serializer_if #(
    parameter int WORD_WIDTH = 16
);
    logic                  snk_valid;
    logic                  snk_ready;
    logic [WORD_WIDTH-1:0] snk;
    logic                  tx_valid;
    logic                  tx_ready;
    logic [7:0]            tx;
    logic                  busy;

    modport slave (
        input  snk_valid, snk, tx_ready,
        output snk_ready, tx_valid, tx, busy
    );

    modport master (
        output snk_valid, snk, tx_ready,
        input  snk_ready, tx_valid, tx, busy
    );
endinterface

// File: rtl/sink_serializer.sv
// Buffers network_sink words in a small FIFO and replays each one as a
// big-endian byte stream towards the host transmitter.
module sink_serializer #(
    parameter int WORD_WIDTH = 16,
    parameter int FIFO_DEPTH = 4
) (
    input logic              clk,
    input logic              rst,
    sink_serializer_if.slave bus
);
    localparam int NUM_BYTES = (WORD_WIDTH + 7) / 8;
    localparam int FRAME_W   = 8 * NUM_BYTES;
    localparam int PAD       = FRAME_W - WORD_WIDTH;
    localparam int PTR_W     = $clog2(FIFO_DEPTH);
    localparam int CNT_W     = $clog2(FIFO_DEPTH + 1);
    localparam int IDX_W     = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;

    typedef enum logic {IDLE, SEND} state_t;

    logic [WORD_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      count;
    state_t                state;
    logic [IDX_W-1:0]      byte_idx;
    logic [FRAME_W-1:0]    shift_reg;

    logic                  full;
    logic                  push;
    logic                  pop;
    logic                  last_byte;
    logic [FRAME_W-1:0]    head_frame;

    assign full      = (count == CNT_W'(FIFO_DEPTH));
    assign push      = bus.snk_valid && !full && !rst;
    assign last_byte = (byte_idx == IDX_W'(NUM_BYTES - 1));
    // The next word is fetched either from idle or on the edge its predecessor's
    // last byte leaves, so a queued word never costs a bubble.
    assign pop       = (count != '0) &&
                       ((state == IDLE) || (bus.tx_ready && last_byte));
    // Left-align the head word so byte 0 always carries the opcode bits.
    assign head_frame = FRAME_W'(mem[rd_ptr]) << PAD;

    assign bus.snk_ready = !full && !rst;
    assign bus.tx_valid  = (state == SEND) && !rst;
    assign bus.tx        = rst ? 8'h00 : shift_reg[FRAME_W-1 -: 8];
    assign bus.busy      = !rst && ((count != '0) || (state == SEND));

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= bus.snk;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            state     <= IDLE;
            byte_idx  <= '0;
            shift_reg <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                count <= count + CNT_W'(1);
            end else if (pop && !push) begin
                count <= count - CNT_W'(1);
            end

            case (state)
                IDLE: begin
                    if (pop) begin
                        shift_reg <= head_frame;
                        byte_idx  <= '0;
                        state     <= SEND;
                    end
                end
                SEND: begin
                    if (bus.tx_ready) begin
                        if (!last_byte) begin
                            shift_reg <= shift_reg << 8;
                            byte_idx  <= byte_idx + IDX_W'(1);
                        end else if (pop) begin
                            shift_reg <= head_frame;
                            byte_idx  <= '0;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sink_serializer.sv
// Randomised and directed bench for sink_serializer at WORD_WIDTH 16, 12 and 3;
// the 16-bit instance is scored continuously against a byte-queue model.
module tb_sink_serializer;
    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    sink_serializer_if #(.WORD_WIDTH(16)) bus16();
    sink_serializer_if #(.WORD_WIDTH(12)) bus12();
    sink_serializer_if #(.WORD_WIDTH(3))  bus3();

    sink_serializer #(.WORD_WIDTH(16), .FIFO_DEPTH(4)) dut16 (.clk(clk), .rst(rst), .bus(bus16));
    sink_serializer #(.WORD_WIDTH(12), .FIFO_DEPTH(4)) dut12 (.clk(clk), .rst(rst), .bus(bus12));
    sink_serializer #(.WORD_WIDTH(3),  .FIFO_DEPTH(4)) dut3  (.clk(clk), .rst(rst), .bus(bus3));

    logic [7:0] exp16[$];
    int         got16 = 0;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_tx = 8'h00;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Byte k of a word once it is left-aligned into whole bytes, MSB first.
    function automatic logic [7:0] frameByte(input int width, input logic [31:0] word, input int k);
        int nb;
        logic [31:0] f;
        nb = (width + 7) / 8;
        f  = word << (8 * nb - width);
        return f[8 * (nb - 1 - k) +: 8];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [15:0] word, input int maxCycles, output bit accepted);
        accepted = 1'b0;
        bus16.snk       = word;
        bus16.snk_valid = 1'b1;
        for (int i = 0; i < maxCycles && !accepted; i++) begin
            if (bus16.snk_ready) accepted = 1'b1;
            tick();
        end
        bus16.snk_valid = 1'b0;
    endtask

    task automatic waitIdle16(input int maxCycles);
        int n = 0;
        while (bus16.busy && n < maxCycles) begin
            tick();
            n++;
        end
        checkOutput("drain_idle", 32'(bus16.busy), 0);
    endtask

    // Scoreboard: every accepted word appends its bytes, every accepted byte
    // must be the oldest outstanding one, and a stalled byte must not move.
    always @(negedge clk) begin
        if (rst) begin
            exp16.delete();
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                checkOutput("stall_valid", 32'(bus16.tx_valid), 1);
                checkOutput("stall_tx", 32'(bus16.tx), 32'(prev_tx));
            end
            if (bus16.tx_valid && bus16.tx_ready) begin
                checkOutput("exp_avail", 32'(exp16.size() > 0), 1);
                if (exp16.size() > 0) checkOutput("tx_byte", 32'(bus16.tx), 32'(exp16.pop_front()));
                got16++;
            end
            if (bus16.snk_valid && bus16.snk_ready) begin
                for (int k = 0; k < 2; k++) exp16.push_back(frameByte(16, 32'(bus16.snk), k));
            end
            prev_stall = bus16.tx_valid && !bus16.tx_ready;
            prev_tx    = bus16.tx;
        end
    end

    initial begin
        bit          acc;
        int          start;
        logic [15:0] held;
        logic [2:0]  w3 [3];
        logic [15:0] w16 [3];

        rst = 1'b1;
        bus16.snk_valid = 1'b0; bus16.snk = '0; bus16.tx_ready = 1'b0;
        bus12.snk_valid = 1'b0; bus12.snk = '0; bus12.tx_ready = 1'b0;
        bus3.snk_valid  = 1'b0; bus3.snk  = '0; bus3.tx_ready  = 1'b0;
        tick();
        tick();
        checkOutput("rst_snk_ready", 32'(bus16.snk_ready), 0);
        checkOutput("rst_tx_valid", 32'(bus16.tx_valid), 0);
        checkOutput("rst_busy", 32'(bus16.busy), 0);
        checkOutput("rst_tx", 32'(bus16.tx), 0);
        rst = 1'b0;
        tick();
        checkOutput("idle_snk_ready16", 32'(bus16.snk_ready), 1);
        checkOutput("idle_tx_valid16", 32'(bus16.tx_valid), 0);
        checkOutput("idle_busy12", 32'(bus12.busy), 0);
        checkOutput("idle_busy3", 32'(bus3.busy), 0);

        // 12-bit word: two bytes, last one zero-padded, first byte two edges after the push.
        bus12.tx_ready = 1'b1;
        bus12.snk = 12'hABC;
        bus12.snk_valid = 1'b1;
        checkOutput("w12_ready", 32'(bus12.snk_ready), 1);
        tick();
        bus12.snk_valid = 1'b0;
        checkOutput("w12_lat_valid", 32'(bus12.tx_valid), 0);
        checkOutput("w12_lat_busy", 32'(bus12.busy), 1);
        tick();
        checkOutput("w12_b0_valid", 32'(bus12.tx_valid), 1);
        checkOutput("w12_b0", 32'(bus12.tx), 32'(frameByte(12, 32'h0ABC, 0)));
        tick();
        checkOutput("w12_b1_valid", 32'(bus12.tx_valid), 1);
        checkOutput("w12_b1", 32'(bus12.tx), 32'(frameByte(12, 32'h0ABC, 1)));
        tick();
        checkOutput("w12_end_valid", 32'(bus12.tx_valid), 0);
        checkOutput("w12_end_busy", 32'(bus12.busy), 0);

        // 3-bit words: one byte each, back-to-back.
        w3[0] = 3'b101;
        w3[1] = 3'($urandom_range(0, 7));
        w3[2] = 3'($urandom_range(0, 7));
        bus3.tx_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (i < 3) begin
                bus3.snk = w3[i];
                bus3.snk_valid = 1'b1;
            end else begin
                bus3.snk_valid = 1'b0;
            end
            tick();
            if (i >= 1 && i <= 3) begin
                checkOutput("w3_valid", 32'(bus3.tx_valid), 1);
                checkOutput("w3_byte", 32'(bus3.tx), 32'(frameByte(3, 32'(w3[i-1]), 0)));
            end else begin
                checkOutput("w3_gap_valid", 32'(bus3.tx_valid), 0);
            end
        end
        bus3.snk_valid = 1'b0;

        // Back-to-back 16-bit words: six bytes with no gap between words.
        w16[0] = 16'h1234; w16[1] = 16'h5678; w16[2] = 16'h9ABC;
        bus16.tx_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (i < 3) begin
                bus16.snk = w16[i];
                bus16.snk_valid = 1'b1;
            end else begin
                bus16.snk_valid = 1'b0;
            end
            tick();
            if (i >= 1 && i <= 6) begin
                checkOutput("b2b_valid", 32'(bus16.tx_valid), 1);
                checkOutput("b2b_byte", 32'(bus16.tx), 32'(frameByte(16, 32'(w16[(i-1)/2]), (i-1) % 2)));
            end else begin
                checkOutput("b2b_edge_valid", 32'(bus16.tx_valid), 0);
            end
        end

        // Back-pressure: five words fit (one in the serializer, four buffered).
        bus16.tx_ready = 1'b0;
        start = got16;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(16'($urandom), 4, acc);
            checkOutput("bp_accept", 32'(acc), 1);
        end
        checkOutput("bp_full_ready", 32'(bus16.snk_ready), 0);
        checkOutput("bp_full_busy", 32'(bus16.busy), 1);
        held = 16'($urandom);
        applyStimulus(held, 10, acc);
        checkOutput("bp_sixth_held", 32'(acc), 0);
        bus16.tx_ready = 1'b1;
        applyStimulus(held, 20, acc);
        checkOutput("bp_sixth_accept", 32'(acc), 1);
        waitIdle16(100);
        checkOutput("bp_bytes", 32'(got16 - start), 12);
        checkOutput("bp_model_empty", 32'(exp16.size()), 0);

        // Random traffic with a 30% downstream duty cycle.
        for (int c = 0; c < 400; c++) begin
            bus16.tx_ready  = ($urandom_range(0, 9) < 3);
            bus16.snk_valid = 1'($urandom_range(0, 1));
            bus16.snk       = 16'($urandom);
            tick();
        end
        bus16.snk_valid = 1'b0;
        bus16.tx_ready  = 1'b1;
        waitIdle16(200);
        checkOutput("rand_model_empty", 32'(exp16.size()), 0);

        // Reset after the first byte of 0xDEAD with two more words queued.
        bus16.tx_ready = 1'b0;
        applyStimulus(16'hDEAD, 4, acc);
        applyStimulus(16'($urandom), 4, acc);
        applyStimulus(16'($urandom), 4, acc);
        checkOutput("mid_b0_valid", 32'(bus16.tx_valid), 1);
        checkOutput("mid_b0", 32'(bus16.tx), 32'hDE);
        bus16.tx_ready = 1'b1;
        tick();
        bus16.tx_ready = 1'b0;
        checkOutput("mid_b1", 32'(bus16.tx), 32'hAD);
        rst = 1'b1;
        #1;
        checkOutput("mid_rst_snk_ready", 32'(bus16.snk_ready), 0);
        checkOutput("mid_rst_tx_valid", 32'(bus16.tx_valid), 0);
        checkOutput("mid_rst_busy", 32'(bus16.busy), 0);
        checkOutput("mid_rst_tx", 32'(bus16.tx), 0);
        tick();
        rst = 1'b0;
        bus16.tx_ready = 1'b1;
        start = got16;
        for (int i = 0; i < 5; i++) begin
            tick();
            checkOutput("post_rst_quiet", {30'd0, bus16.tx_valid, bus16.busy}, 0);
        end
        checkOutput("post_rst_ready", 32'(bus16.snk_ready), 1);
        applyStimulus(16'h0102, 4, acc);
        checkOutput("post_rst_accept", 32'(acc), 1);
        waitIdle16(50);
        checkOutput("post_rst_bytes", 32'(got16 - start), 2);
        checkOutput("post_rst_model_empty", 32'(exp16.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
